// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and line levels for the start/data/stop serial link
package serial_pkg;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: byte source handshake into the serial transmitter
//   in_data  : byte offered by the source
//   in_valid : source has a byte
//   in_ready : transmitter can accept (idle only)
interface serial_tx_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/serial_baud_tick.sv
// serial_baud_tick: bit-period timer, bit_tick marks the last clock of each bit period
//   clk, reset : clock and synchronous active-high reset
//   clear      : hold the count at the start of a bit period
//   bit_tick   : terminal count of the current bit period
module serial_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt_q;
  assign bit_tick = cnt_q == LAST;
  always_ff @(posedge clk)
    cnt_q <= (reset || clear || bit_tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: start/data(LSB first)/parity/stop frame transmitter
//   clk, reset : clock and synchronous active-high reset
//   in_if      : byte handshake (slave), accepted only when idle
//   serial_out : registered line, idles high
//   busy       : frame in progress
//   done       : one-cycle pulse in the first idle cycle after the last stop period
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic reset,
  serial_tx_if.slave in_if,
  output logic serial_out,
  output logic busy,
  output logic done
);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  tx_state_t state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BW-1:0] bit_q;
  logic parity_q, line_q, done_q, bit_tick;
  // baud timer stays cleared in idle so the start bit gets a full period
  serial_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .reset(reset),
    .clear(state_q == TX_IDLE),
    .bit_tick(bit_tick)
  );
  assign in_if.in_ready = state_q == TX_IDLE;
  assign busy = state_q != TX_IDLE;
  assign serial_out = line_q;
  assign done = done_q;
  // line_q is loaded with the level of the state being entered so it changes with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      shift_q <= '0;
      bit_q <= '0;
      parity_q <= 1'b0;
      line_q <= IDLE_LEVEL;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TX_IDLE: if (in_if.in_valid) begin
          shift_q <= in_if.in_data;
          parity_q <= (^in_if.in_data) ^ 1'(PARITY_ODD);
          state_q <= TX_START;
          line_q <= START_LEVEL;
        end
        TX_START: if (bit_tick) begin
          state_q <= TX_DATA;
          line_q <= shift_q[0];
          bit_q <= '0;
        end
        TX_DATA: if (bit_tick) begin
          if (bit_q == LAST_DATA) begin
            bit_q <= '0;
            state_q <= (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            line_q <= (PARITY_EN != 0) ? parity_q : STOP_LEVEL;
          end else begin
            bit_q <= bit_q + 1'b1;
            shift_q <= shift_q >> 1;
            line_q <= shift_q[1];
          end
        end
        TX_PARITY: if (bit_tick) begin
          state_q <= TX_STOP;
          line_q <= STOP_LEVEL;
          bit_q <= '0;
        end
        TX_STOP: if (bit_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_q <= '0;
            state_q <= TX_IDLE;
            line_q <= IDLE_LEVEL;
            done_q <= 1'b1;
          end else bit_q <= bit_q + 1'b1;
        end
        default: begin
          state_q <= TX_IDLE;
          line_q <= IDLE_LEVEL;
        end
      endcase
    end
  end
endmodule
